uart_tx_buffered: RTL
=====================

# uart_tx_buffered

Buffered UART transmitter that sits directly downstream of the LED/7-segment status message generator. It absorbs that generator's back-to-back byte bursts (one byte per cycle, no backpressure) into a small FIFO. It then serialises each byte onto the board's UART TX line as 8N1 (or 8E1) frames at a fixed baud divisor. It is the last stage before the `tx` pin.

## Interface
- `DATA_WIDTH`, 8, bits per character; fixed at 8 for UART framing.
- `FIFO_DEPTH`, 16, FIFO entries; power of two, ≥ 2.
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200); ≥ 2.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `ena` in 1: global enable; when low, all state frozen.
- `in_data` in DATA_WIDTH: byte from the message generator.
- `in_valid` in 1: `in_data` valid this cycle; single-cycle pulses, possibly back-to-back.
- `in_ready` out 1: FIFO not full (`fifo_count < FIFO_DEPTH`); advisory only, since upstream ignores it.
- `tx` out 1: UART serial output, idle high, registered.
- `busy` out 1: high whenever FSM is not IDLE.
- `fifo_count` out $clog2(FIFO_DEPTH+1): current FIFO occupancy.
- `overflow` out 1: sticky; set when a valid byte is dropped because the FIFO is full.

## Operation
- Reset values: `tx`=1, `busy`=0, `in_ready`=1, `fifo_count`=0, `overflow`=0, FSM=IDLE, baud counter=0, bit index=0.
- Write rule: with `ena` high, a byte is written when `in_valid` is high and `fifo_count < FIFO_DEPTH`.
  - Fullness is judged on the registered count before any same-cycle pop.
  - A write while full is dropped, sets `overflow`, and leaves FIFO contents untouched.
- Simultaneous push and pop (not full): `fifo_count` is unchanged and both operations take effect.
- Pointers wrap modulo FIFO_DEPTH. `overflow` clears only on reset.
- FSM states:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, drive `tx`=0, load the baud counter with CLKS_PER_BIT-1, and go to START.
  - START: hold 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: drive `shift[0]` (LSB first). Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to PARITY if enabled, else STOP.
  - PARITY (macro only): drive the even-parity bit (XOR of the 8 data bits) for one bit period, then go to STOP.
  - STOP: drive 1 for one bit period. At the end:
    - if the FIFO is non-empty, pop and go directly to START with no idle gap;
    - otherwise go to IDLE.
- Baud counter: counts down from CLKS_PER_BIT-1; a bit boundary occurs when it reaches 0, then it reloads.
- All data bytes, including 0x00, are transmitted verbatim.
- `ena` low: FSM, baud counter, FIFO pointers and `overflow` all hold; `in_valid` is ignored (not counted as overflow); `tx` holds its current level.
- Reset mid-frame: `tx` returns to 1 immediately (asynchronously) and the FIFO is emptied. No partial frame resumes.

## Timing
- Write on edge E into an empty FIFO with FSM IDLE:
  - `fifo_count`=1 after E;
  - at E+1 the FSM pops, and `tx` goes 0, `busy` 1, `fifo_count` 0.
- Frame length: 10×CLKS_PER_BIT cycles (11× with parity), measured from `tx` falling to the next start bit or to IDLE.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `busy` falls on the edge where STOP completes with the FIFO empty.
- `in_ready` and `fifo_count` are registered and update on the edge after push/pop.
- A burst of 11 consecutive `in_valid` cycles into an empty FIFO of depth 16 never overflows.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: PARITY state present; frame is start + 8 data + even parity + stop (11 bits).
- Undefined: no PARITY state or logic; frame is 8N1 (10 bits).

## Test plan
- CLKS_PER_BIT=4, no parity. Single byte 0xA5 written to an idle block -> `tx` = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles, starting at E+1; `busy` high for 40 cycles.
- Burst of 11 bytes "LD: 0x3C0F" plus 0x00 on consecutive cycles -> `fifo_count` peaks at 10; 11 contiguous frames with no idle gaps; `overflow`=0.
- FIFO_DEPTH=4: 6 back-to-back writes -> bytes 1–5 transmitted, byte 6 dropped (4 stored after byte 1 is popped); `overflow`=1 and stays set.
- `ena` low for 7 cycles in the middle of data bit 3 -> `tx` level held, and that bit's total width is 4+7 cycles; remaining bits unchanged.
- Reset asserted mid-DATA with 3 bytes queued -> `tx`=1, `busy`=0, `fifo_count`=0 immediately; nothing is transmitted after release without new writes.
- `UART_TX_PARITY_EN` defined, byte 0x07 -> parity bit 1, frame of 11 bits (44 cycles); byte 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// ============================================================================
// Module  : uart_tx_buffered
// Brief   : FIFO-buffered UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN
//           is defined) with sticky overflow flag and global enable.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_buffered #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ena,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              tx,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overflow
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_WIDTH);

    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [BAUD_W-1:0]     r_baud_cnt;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
`ifdef UART_TX_PARITY_EN
    logic                  r_parity;
`endif

    logic                  w_bit_end;
    logic                  w_not_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_count_next;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_bit_end   = (r_baud_cnt == '0);
    assign w_not_empty = (fifo_count != '0);
    // Fullness uses the registered count, so a same-cycle pop never frees room.
    assign w_push      = ena && in_valid && (fifo_count != DEPTH_C);
    assign w_pop       = ena && w_not_empty &&
                         ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
    assign w_head      = r_mem[r_rd_ptr];

    always_comb begin
        w_count_next = fifo_count;
        if (w_push && !w_pop) begin
            w_count_next = fifo_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = fifo_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            fifo_count <= '0;
            in_ready   <= 1'b1;
            overflow   <= 1'b0;
        end else if (ena) begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            fifo_count <= w_count_next;
            in_ready   <= (w_count_next != DEPTH_C);
            if (in_valid && !w_push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else if (ena) begin
            // A pop only happens from IDLE or at the end of STOP, so both
            // share one frame-launch path with no idle gap between frames.
            if (w_pop) begin
                r_shift    <= w_head;
`ifdef UART_TX_PARITY_EN
                r_parity   <= ^w_head;
`endif
                tx         <= 1'b0;
                busy       <= 1'b1;
                r_baud_cnt <= BAUD_RELOAD;
                r_state    <= S_START;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        tx   <= 1'b1;
                        busy <= 1'b0;
                    end
                    S_START: begin
                        if (w_bit_end) begin
                            r_baud_cnt <= BAUD_RELOAD;
                            r_bit_idx  <= '0;
                            tx         <= r_shift[0];
                            r_state    <= S_DATA;
                        end else begin
                            r_baud_cnt <= r_baud_cnt - BAUD_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (w_bit_end) begin
                            r_baud_cnt <= BAUD_RELOAD;
                            if (r_bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                                tx      <= r_parity;
                                r_state <= S_PARITY;
`else
                                tx      <= 1'b1;
                                r_state <= S_STOP;
`endif
                            end else begin
                                r_bit_idx <= r_bit_idx + IDX_W'(1);
                                r_shift   <= r_shift >> 1;
                                tx        <= r_shift[1];
                            end
                        end else begin
                            r_baud_cnt <= r_baud_cnt - BAUD_W'(1);
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    S_PARITY: begin
                        if (w_bit_end) begin
                            r_baud_cnt <= BAUD_RELOAD;
                            tx         <= 1'b1;
                            r_state    <= S_STOP;
                        end else begin
                            r_baud_cnt <= r_baud_cnt - BAUD_W'(1);
                        end
                    end
`endif
                    S_STOP: begin
                        if (w_bit_end) begin
                            tx      <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_baud_cnt <= r_baud_cnt - BAUD_W'(1);
                        end
                    end
                    default: begin
                        tx      <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
